// File: rtl/chunk_register.sv
// Chunk-addressable word register: direct per-lane loads plus an atomic MSB-first sequential fill.
// Optional registered even-parity output is enabled by defining CHUNK_REGISTER_PARITY_EN.
module chunk_register #(
  parameter int CHUNK_W    = 8,
  parameter int NUM_CHUNKS = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHUNK_W-1:0]            chunk_in,
  input  logic [NUM_CHUNKS-1:0]         lane_load,
  input  logic                          seq_start,
  input  logic                          chunk_valid,
  output logic                          chunk_ready,
  input  logic                          abort,
  output logic [CHUNK_W*NUM_CHUNKS-1:0] value_out,
  output logic                          busy,
  output logic                          done
`ifdef CHUNK_REGISTER_PARITY_EN
  ,
  output logic                          parity_out
`endif
);

  localparam int W     = CHUNK_W * NUM_CHUNKS;
  localparam int PTR_W = $clog2(NUM_CHUNKS);
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COMMIT
  } state_t;

  state_t           state;
  state_t           nextState;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] nextPtr;
  logic [W-1:0]     staging;
  logic [W-1:0]     nextStaging;
  logic [W-1:0]     nextValue;
  logic             nextDone;
  logic [PTR_W-1:0] topLane;

  assign chunk_ready = (state == FILL) && !abort;
  assign busy        = (state != IDLE);

  // Highest-indexed set strobe wins when several lanes are requested together.
  always_comb begin
    topLane = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (lane_load[i]) topLane = PTR_W'(i);
    end
  end

  always_comb begin
    nextState   = state;
    nextPtr     = ptr;
    nextStaging = staging;
    nextValue   = value_out;
    nextDone    = 1'b0;
    case (state)
      IDLE: begin
        if (|lane_load) begin
          nextValue[int'(topLane)*CHUNK_W +: CHUNK_W] = chunk_in;
        end else if (seq_start) begin
          nextState   = FILL;
          nextPtr     = LAST_LANE;
          nextStaging = '0;
        end
      end
      FILL: begin
        if (abort) begin
          nextState   = IDLE;
          nextPtr     = LAST_LANE;
          nextStaging = '0;
        end else if (chunk_valid) begin
          nextStaging[int'(ptr)*CHUNK_W +: CHUNK_W] = chunk_in;
          if (ptr == '0) nextState = COMMIT;
          else           nextPtr   = ptr - PTR_W'(1);
        end
      end
      COMMIT: begin
        // value_out only ever changes here during a fill, so readers never see a partial word.
        nextValue = staging;
        nextDone  = 1'b1;
        nextState = IDLE;
        nextPtr   = LAST_LANE;
      end
      default: begin
        nextState = IDLE;
        nextPtr   = LAST_LANE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= LAST_LANE;
      staging   <= '0;
      value_out <= '0;
      done      <= 1'b0;
    end else begin
      state     <= nextState;
      ptr       <= nextPtr;
      staging   <= nextStaging;
      value_out <= nextValue;
      done      <= nextDone;
    end
  end

`ifdef CHUNK_REGISTER_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset) parity_out <= 1'b0;
    else       parity_out <= ^nextValue;
  end
`endif

endmodule

// File: tb/tb_chunk_register.sv
// Self-checking bench for chunk_register (CHUNK_W=8, NUM_CHUNKS=4) using an expected-word scoreboard.
// Define CHUNK_REGISTER_PARITY_EN to also check parity_out.
module tb_chunk_register;

  logic        clock;
  logic        reset;
  logic [7:0]  chunk_in;
  logic [3:0]  lane_load;
  logic        seq_start;
  logic        chunk_valid;
  logic        chunk_ready;
  logic        abort;
  logic [31:0] value_out;
  logic        busy;
  logic        done;
`ifdef CHUNK_REGISTER_PARITY_EN
  logic        parity_out;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model;
  logic [31:0] expQ[$];

  chunk_register #(.CHUNK_W(8), .NUM_CHUNKS(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .chunk_in   (chunk_in),
    .lane_load  (lane_load),
    .seq_start  (seq_start),
    .chunk_valid(chunk_valid),
    .chunk_ready(chunk_ready),
    .abort      (abort),
    .value_out  (value_out),
    .busy       (busy),
    .done       (done)
`ifdef CHUNK_REGISTER_PARITY_EN
    ,
    .parity_out (parity_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ll, input logic [7:0] cin, input logic ss,
                               input logic cv, input logic ab);
    lane_load   = ll;
    chunk_in    = cin;
    seq_start   = ss;
    chunk_valid = cv;
    abort       = ab;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkWord(input string tag);
    checkOutput({tag, "_value"}, value_out, model);
`ifdef CHUNK_REGISTER_PARITY_EN
    checkOutput({tag, "_parity"}, {31'd0, parity_out}, {31'd0, ^model});
`endif
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model = 32'h0;
  endtask

  // Lane load with the expected word computed from the highest set strobe.
  task automatic laneLoad(input logic [3:0] ll, input logic [7:0] cin, input string tag);
    logic [31:0] got;
    applyStimulus(ll, cin, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      if (ll[i]) begin
        model[i*8 +: 8] = cin;
        break;
      end
    end
    expQ.push_back(model);
    tick();
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    got = expQ.pop_front();
    checkOutput(tag, value_out, got);
`ifdef CHUNK_REGISTER_PARITY_EN
    checkOutput({tag, "_parity"}, {31'd0, parity_out}, {31'd0, ^got});
`endif
  endtask

  // Full MSB-first fill; gapAfter inserts one chunk_valid-low cycle after that chunk index.
  task automatic runFill(input logic [31:0] word, input int gapAfter, input string tag);
    int waited;
    applyStimulus(4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    expQ.push_back(word);
    tick();
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_busyFill"}, {31'd0, busy}, 32'd1);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(4'b0000, word[i*8 +: 8], 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput({tag, "_ready"}, {31'd0, chunk_ready}, 32'd1);
      tick();
      checkOutput({tag, "_holdValue"}, value_out, model);
      if (3 - i == gapAfter) begin
        applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput({tag, "_gapHold"}, value_out, model);
      end
    end
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_commitNoDone"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_commitBusy"}, {31'd0, busy}, 32'd1);
    waited = 0;
    while (!done && waited < 8) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_doneLatency"}, waited, 1);
    if (done) begin
      model = expQ.pop_front();
      checkWord({tag, "_commit"});
    end
    checkOutput({tag, "_idleAfter"}, {31'd0, busy}, 32'd0);
    tick();
    checkOutput({tag, "_donePulse"}, {31'd0, done}, 32'd0);
    checkWord({tag, "_stable"});
  endtask

  initial begin
    reset = 1'b0;
    model = 32'h0;
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    doReset();
    checkWord("reset0");

    // Reset clears a loaded word.
    laneLoad(4'b1000, 8'hDE, "loadDE");
    laneLoad(4'b0100, 8'hAD, "loadAD");
    laneLoad(4'b0010, 8'hBE, "loadBE");
    laneLoad(4'b0001, 8'hEF, "loadEF");
    checkOutput("deadbeef", value_out, 32'hDEADBEEF);
    doReset();
    checkOutput("rst_value", value_out, 32'h0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_ready", {31'd0, chunk_ready}, 32'd0);

    laneLoad(4'b0100, 8'hA7, "laneA7");
    checkOutput("laneA7_const", value_out, 32'h00A70000);
`ifdef CHUNK_REGISTER_PARITY_EN
    checkOutput("laneA7_parity1", {31'd0, parity_out}, 32'd1);
`endif
    doReset();
    laneLoad(4'b1001, 8'h3C, "lane3C");
    checkOutput("lane3C_const", value_out, 32'h3C000000);

    // lane_load wins over a simultaneous seq_start.
    applyStimulus(4'b0010, 8'h5A, 1'b1, 1'b0, 1'b0);
    model[15:8] = 8'h5A;
    tick();
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("prio_busy", {31'd0, busy}, 32'd0);
    checkWord("prio");

    runFill(32'h11223344, 1, "fill1");
    checkOutput("fill1_const", value_out, 32'h11223344);

    // Abort after two chunks, together with chunk_valid.
    applyStimulus(4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0000, 8'h99, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b0000, 8'h88, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b1111, 8'h77, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("abort_ready", {31'd0, chunk_ready}, 32'd0);
    tick();
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkWord("abort");
    for (int i = 0; i < 3; i++) begin
      checkOutput("abort_noDone", {31'd0, done}, 32'd0);
      tick();
    end
    checkWord("abortLater");

    // lane_load during FILL is ignored.
    applyStimulus(4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0100, 8'hF0, 1'b0, 1'b0, 1'b0);
    tick();
    checkWord("fillLaneIgnored");

    // Reset mid-fill after three chunks, then a clean fill.
    doReset();
    applyStimulus(4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0000, 8'h61 + 8'(i), 1'b0, 1'b1, 1'b0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    model = 32'h0;
    checkWord("midReset");
    checkOutput("midReset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midReset_done", {31'd0, done}, 32'd0);
    runFill(32'hAABBCCDD, -1, "fill2");
    checkOutput("fill2_const", value_out, 32'hAABBCCDD);

    // Random multi-strobe lane loads.
    for (int n = 0; n < 8; n++) begin
      laneLoad(4'($urandom_range(1, 15)), 8'($urandom_range(0, 255)), "randLane");
    end

    checkOutput("queueEmpty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
